multicycle_controller: RTL

- Parametrised multi-cycle control unit for the RV32I-subset core: lw, sw, R-type/I-type add/sub/and/or/slt, beq, jal.
- Replaces single-cycle combinational control. A Moore FSM sequences one shared memory port, the ALU and the register file over 3–5 cycles per instruction.
- Handles variable-latency memory through a req/ready handshake, traps illegal encodings, and counts retired instructions.

---
 rtl/multicycle_controller_if.sv | 9 +
 rtl/multicycle_controller.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: shared memory port handshake between controller and memory
interface multicycle_controller_if;
  logic mem_req;
  logic mem_ready;
  logic memwrite;
  logic adrsrc;
  modport master(output mem_req, memwrite, adrsrc, input mem_ready);
  modport slave(input mem_req, memwrite, adrsrc, output mem_ready);
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing memory, ALU and register file for the RV32I subset
module multicycle_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset,
  input logic [6:0] op,
  input logic [2:0] funct3,
  input logic funct7b5,
  input logic zero,
  multicycle_controller_if.master mem,
  output logic irwrite,
  output logic pcwrite,
  output logic regwrite,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluctrl,
  output logic [1:0] immsrc,
  output logic [1:0] resultsrc,
  output logic illegal_instr,
  output logic retire,
  output logic [CNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, JAL, BEQ, TRAP
  } state_t;
  state_t state, state_n;
  logic done, alu_f3, is_lw, is_sw, is_r, is_i, is_beq, is_jal;
  logic [2:0] alu_dec;
  assign done = MEM_HANDSHAKE ? mem.mem_ready : 1'b1;
  assign alu_f3 = funct3 == 3'b000 || funct3 == 3'b010 || funct3 == 3'b110 || funct3 == 3'b111;
  assign is_lw = op == 7'b0000011 && funct3 == 3'b010;
  assign is_sw = op == 7'b0100011 && funct3 == 3'b010;
  assign is_r = op == 7'b0110011 && alu_f3 && (!funct7b5 || funct3 == 3'b000);
  assign is_i = op == 7'b0010011 && alu_f3;
  assign is_beq = op == 7'b1100011 && funct3 == 3'b000;
  assign is_jal = op == 7'b1101111;
  // is_r is false for I-type, so EXECUTEI can never select sub
  assign alu_dec = funct3 == 3'b000 ? {2'b00, is_r & funct7b5} :
                   funct3 == 3'b010 ? 3'b101 :
                   funct3 == 3'b110 ? 3'b011 : 3'b010;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      instr_count <= '0;
    end else begin
      state <= state_n;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end
  always_comb begin
    state_n = state;
    mem.mem_req = 1'b0;
    mem.memwrite = 1'b0;
    mem.adrsrc = 1'b0;
    irwrite = 1'b0;
    pcwrite = 1'b0;
    regwrite = 1'b0;
    alusrca = 2'b00;
    alusrcb = 2'b00;
    aluctrl = 3'b000;
    immsrc = 2'b00;
    resultsrc = 2'b00;
    illegal_instr = 1'b0;
    retire = 1'b0;
    case (state)
      FETCH: begin
        mem.mem_req = 1'b1;
        alusrcb = 2'b10;
        resultsrc = 2'b10;
        irwrite = done;
        pcwrite = done;
        state_n = done ? DECODE : FETCH;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        immsrc = 2'b10;
        state_n = is_lw || is_sw ? MEMADR : is_r ? EXECUTER : is_i ? EXECUTEI :
                  is_jal ? JAL : is_beq ? BEQ : ILLEGAL_TRAP ? TRAP : FETCH;
      end
      MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        immsrc = {1'b0, is_sw};
        state_n = is_sw ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem.mem_req = 1'b1;
        mem.adrsrc = 1'b1;
        state_n = done ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        resultsrc = 2'b01;
        regwrite = 1'b1;
        retire = 1'b1;
        state_n = FETCH;
      end
      MEMWRITE: begin
        mem.mem_req = 1'b1;
        mem.adrsrc = 1'b1;
        mem.memwrite = done;
        retire = done;
        state_n = done ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        alusrca = 2'b10;
        aluctrl = alu_dec;
        state_n = ALUWB;
      end
      EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluctrl = alu_dec;
        state_n = ALUWB;
      end
      ALUWB: begin
        regwrite = 1'b1;
        retire = 1'b1;
        state_n = FETCH;
      end
      JAL: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
        state_n = ALUWB;
      end
      BEQ: begin
        alusrca = 2'b10;
        aluctrl = 3'b001;
        pcwrite = zero;
        retire = 1'b1;
        state_n = FETCH;
      end
      TRAP: illegal_instr = 1'b1;
      default: state_n = FETCH;
    endcase
    // reset held low silences every strobe and select regardless of state
    if (!reset) begin
      mem.mem_req = 1'b0;
      mem.memwrite = 1'b0;
      mem.adrsrc = 1'b0;
      irwrite = 1'b0;
      pcwrite = 1'b0;
      regwrite = 1'b0;
      alusrca = 2'b00;
      alusrcb = 2'b00;
      aluctrl = 3'b000;
      immsrc = 2'b00;
      resultsrc = 2'b00;
      illegal_instr = 1'b0;
      retire = 1'b0;
    end
  end
endmodule
